// File: rtl/lamp_shift_driver.sv
// Serial output stage for the lamp sequencer: shifts a WIDTH-bit lamp vector MSB-first
// into a 74HC595-style chain and pulses the storage latch whenever the vector changes.
module lamp_shift_driver #(
  parameter int WIDTH = 16,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] lamp,
  output logic             sclk,
  output logic             sdo,
  output logic             rclk,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, SH_LO, SH_HI, LATCH} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sent;
  logic [WIDTH-1:0] shreg_rot;
  logic             force_pend;
  logic [BW-1:0]    bitcnt;
  logic [DW-1:0]    divcnt;

  // Rotating instead of shifting returns shreg to the original frame after WIDTH
  // steps, so the latched value can be recorded into sent without a second copy.
  always_comb begin
    shreg_rot = (shreg << 1) | (shreg >> (WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      sent       <= '0;
      force_pend <= 1'b1;
      bitcnt     <= '0;
      divcnt     <= '0;
      sclk       <= 1'b0;
      sdo        <= 1'b0;
      rclk       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (force_pend || (lamp != sent)) begin
            shreg      <= lamp;
            sdo        <= lamp[WIDTH-1];
            force_pend <= 1'b0;
            bitcnt     <= '0;
            divcnt     <= '0;
            busy       <= 1'b1;
            state      <= SH_LO;
          end
        end
        SH_LO: begin
          if (divcnt == DIV_LAST) begin
            divcnt <= '0;
            sclk   <= 1'b1;
            state  <= SH_HI;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        SH_HI: begin
          if (divcnt == DIV_LAST) begin
            divcnt <= '0;
            sclk   <= 1'b0;
            shreg  <= shreg_rot;
            if (bitcnt == BIT_LAST) begin
              rclk  <= 1'b1;
              state <= LATCH;
            end else begin
              bitcnt <= bitcnt + 1'b1;
              sdo    <= shreg_rot[WIDTH-1];
              state  <= SH_LO;
            end
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        LATCH: begin
          if (divcnt == DIV_LAST) begin
            divcnt <= '0;
            rclk   <= 1'b0;
            busy   <= 1'b0;
            sdo    <= 1'b0;
            sent   <= shreg;
            done   <= 1'b1;
            state  <= IDLE;
          end else begin
            divcnt <= divcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
